spi_mem_arbiter: RTL

Shares the single SPI memory master between two requesters: the CPU fetch/load/store path and the debug/loader port. It accepts one request at a time, drives the SPI master's start/direction/address/write-data, waits for completion, and returns read data plus a one-cycle acknowledge to the winning requester. It sits between the CPU control FSM and the SPI master, replacing the direct spiStart/rwb connection.

---
 rtl/spi_mem_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: shares one SPI memory master between the CPU path and the debug/loader port.
// Optional macro SPI_ARB_ROUND_ROBIN_EN: ties go to the port not granted last (default: debug wins ties).
module spi_mem_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              cpu_req_i,
    input  logic              cpu_rwb_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              dbg_req_i,
    input  logic              dbg_rwb_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              spi_start_o,
    output logic              spi_rwb_o,
    output logic [ADDR_W-1:0] spi_addr_o,
    output logic [DATA_W-1:0] spi_wdata_o,
    input  logic              spi_busy_i,
    input  logic              spi_done_i,
    input  logic [DATA_W-1:0] spi_rdata_i,
    output logic [1:0]        owner_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    state_t            state_r;
    state_t            next_state_s;
    logic              any_req_s;
    logic              grant_dbg_s;
    logic              load_s;
    logic              spi_start_s;
    logic              resp_enter_s;
    logic              finish_s;
    logic              win_dbg_r;
    logic              last_grant_r;   // 1 = debug was granted last
    logic              spi_rwb_r;
    logic [ADDR_W-1:0] spi_addr_r;
    logic [DATA_W-1:0] spi_wdata_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] dbg_rdata_r;
    logic              cpu_ack_r;
    logic              dbg_ack_r;
    logic [1:0]        owner_r;

    assign any_req_s = cpu_req_i || dbg_req_i;

    // Winner selection among requests present in IDLE
    always_comb begin
        if (cpu_req_i && dbg_req_i) begin
            grant_dbg_s = RR_EN ? ~last_grant_r : 1'b1;
        end else begin
            grant_dbg_s = dbg_req_i;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:  next_state_s = any_req_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: next_state_s = spi_busy_i ? ST_ISSUE : ST_WAIT;
            ST_WAIT:  next_state_s = spi_done_i ? ST_RESP : ST_WAIT;
            ST_RESP:  next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // FSM output decode; the start pulse must follow busy within the same cycle
    always_comb begin
        load_s       = 1'b0;
        spi_start_s  = 1'b0;
        resp_enter_s = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE:  load_s       = any_req_s;
            ST_ISSUE: spi_start_s  = ~spi_busy_i;
            ST_WAIT:  resp_enter_s = spi_done_i;
            ST_RESP:  finish_s     = 1'b1;
            default: begin
                load_s       = 1'b0;
                spi_start_s  = 1'b0;
                resp_enter_s = 1'b0;
                finish_s     = 1'b0;
            end
        endcase
    end

    // Request latch: sampled only in IDLE so the SPI command stays stable to RESP
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            win_dbg_r   <= 1'b0;
            spi_rwb_r   <= 1'b0;
            spi_addr_r  <= {ADDR_W{1'b0}};
            spi_wdata_r <= {DATA_W{1'b0}};
        end else if (load_s) begin
            win_dbg_r   <= grant_dbg_s;
            spi_rwb_r   <= grant_dbg_s ? dbg_rwb_i   : cpu_rwb_i;
            spi_addr_r  <= grant_dbg_s ? dbg_addr_i  : cpu_addr_i;
            spi_wdata_r <= grant_dbg_s ? dbg_wdata_i : cpu_wdata_i;
        end
    end

    // Read-data capture into the winner's register; writes leave both untouched
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cpu_rdata_r <= {DATA_W{1'b0}};
            dbg_rdata_r <= {DATA_W{1'b0}};
        end else if (resp_enter_s && spi_rwb_r) begin
            if (win_dbg_r) begin
                dbg_rdata_r <= spi_rdata_i;
            end else begin
                cpu_rdata_r <= spi_rdata_i;
            end
        end
    end

    // Acknowledge pulses, owner indication and last-grant history
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cpu_ack_r    <= 1'b0;
            dbg_ack_r    <= 1'b0;
            owner_r      <= 2'b00;
            last_grant_r <= 1'b1;
        end else begin
            cpu_ack_r <= resp_enter_s && !win_dbg_r;
            dbg_ack_r <= resp_enter_s &&  win_dbg_r;
            if (load_s) begin
                owner_r <= grant_dbg_s ? 2'b10 : 2'b01;
            end else if (finish_s) begin
                owner_r      <= 2'b00;
                last_grant_r <= win_dbg_r;
            end
        end
    end

    assign spi_start_o = spi_start_s;
    assign spi_rwb_o   = spi_rwb_r;
    assign spi_addr_o  = spi_addr_r;
    assign spi_wdata_o = spi_wdata_r;
    assign cpu_ack_o   = cpu_ack_r;
    assign dbg_ack_o   = dbg_ack_r;
    assign cpu_rdata_o = cpu_rdata_r;
    assign dbg_rdata_o = dbg_rdata_r;
    assign owner_o     = owner_r;
    assign state_o     = state_r;

endmodule
